led_trail_fader: RTL and testbench

//  Downstream of knight_rider: takes its raw 8-bit LED pattern and drives the

---
 rtl/led_trail_fader.sv | 86 ++++++++
 tb/tb_led_trail_fader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_trail_fader.sv
// Comet-trail fader: each LED jumps to full brightness while its input is high,
// then decays in fixed steps; brightness is rendered as PWM against a shared counter.

module led_trail_lane #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);
  localparam logic [PWM_BITS-1:0] MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0] level;

  always_ff @(posedge clk) begin
    if (rst) begin
      level   <= '0;
      led_out <= 1'b0;
    end else begin
      // a fresh set wins over a coincident decay tick; decay saturates at 0
      if (set)
        level <= MAX;
      else if (tick)
        level <= (level > STEP) ? level - STEP : '0;
      led_out <= (level == MAX) | (level > pwm_cnt);
    end
  end
endmodule

module led_trail_fader #(
  parameter int N_LEDS     = 8,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 65536,
  parameter int DECAY_STEP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_LEDS-1:0] led_in,
  output logic [N_LEDS-1:0] led_out,
  output logic              pwm_sync
);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  // a 1-bit counter still works for DECAY_DIV=1: it sits at 0 and ticks every cycle
  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   led_in_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DW-1:0]       decay_cnt;
  logic                decay_tick;

  assign decay_tick = (decay_cnt == DLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      led_in_q  <= '0;
      pwm_cnt   <= '0;
      decay_cnt <= '0;
      pwm_sync  <= 1'b0;
    end else begin
      led_in_q  <= led_in;
      pwm_cnt   <= pwm_cnt + 1'b1;
      pwm_sync  <= (pwm_cnt == MAX);
      decay_cnt <= decay_tick ? '0 : decay_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_lane
    led_trail_lane #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .set    (led_in_q[i]),
      .tick   (decay_tick),
      .pwm_cnt(pwm_cnt),
      .led_out(led_out[i])
    );
  end
endmodule

// File: tb/tb_led_trail_fader.sv
// Directed bench: two faders (decay step 1 and 4) share clock, reset and input;
// expected duty counts are hand-derived for PWM_BITS=4, DECAY_DIV=16.

module tb_led_trail_fader;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_in;
  logic [7:0] out1, out4;
  logic       sync1, sync4;

  int e;        // edges since last reset edge
  int checks = 0;
  int errs   = 0;

  // high-cycles per 16-cycle window after a pulse, step 1 and step 4
  int exp1 [16] = '{16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
  int exp4 [16] = '{16, 11, 7, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  led_trail_fader #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(16), .DECAY_STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .led_in(led_in), .led_out(out1), .pwm_sync(sync1));

  led_trail_fader #(.N_LEDS(8), .PWM_BITS(4), .DECAY_DIV(16), .DECAY_STEP(4)) u_dut4 (
    .clk(clk), .rst(rst), .led_in(led_in), .led_out(out4), .pwm_sync(sync4));

  task automatic step();
    @(posedge clk);
    if (rst) e = 0;
    else     e = e + 1;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // one PWM period of led_out[3] on both DUTs; optional pulse on led_in[3] before step pulse_at
  task automatic window(input int pulse_at, output int c1, output int c4);
    c1 = 0;
    c4 = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i == pulse_at) led_in[3] = 1'b1;
      step();
      led_in[3] = 1'b0;
      c1 += int'(out1[3]);
      c4 += int'(out4[3]);
    end
  endtask

  // pulse led_in[3] so it is sampled on an edge with e%16==15; leaves e%16==0
  task automatic pulse_aligned();
    while (e % 16 != 14) step();
    led_in[3] = 1'b1;
    step();
    led_in[3] = 1'b0;
    step();
  endtask

  initial begin
    int c1, c4, pos, dir;
    e = 0;
    rst = 1'b1;
    led_in = 8'hFF;
    @(negedge clk);

    // reset holds everything low even with all inputs high
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_out1", 32'(out1), 32'h0);
      chk("rst_out4", 32'(out4), 32'h0);
      chk("rst_sync", 32'(sync1), 32'h0);
    end

    // idle: dark LEDs, sync every 16 edges starting at edge 16
    rst = 1'b0;
    led_in = 8'h00;
    for (int i = 0; i < 1000; i++) begin
      step();
      chk("idle_out1", 32'(out1), 32'h0);
      chk("idle_out4", 32'(out4), 32'h0);
      chk("idle_sync", 32'(sync1), 32'(e % 16 == 0));
    end

    // hold: two-edge latency, then continuously lit
    led_in = 8'h01;
    step();
    chk("hold_lat_k", 32'(out1), 32'h0);
    step();
    chk("hold_lat_k1", 32'(out1), 32'h0);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("hold_out1", 32'(out1), 32'h01);
      chk("hold_out4", 32'(out4), 32'h01);
    end
    led_in = 8'h00;
    repeat (300) step();
    for (int i = 0; i < 16; i++) begin
      step();
      chk("hold_faded1", 32'(out1), 32'h0);
      chk("hold_faded4", 32'(out4), 32'h0);
    end

    // fade and saturation: duty steps down one level per decay tick
    pulse_aligned();
    for (int w = 0; w < 16; w++) begin
      window(0, c1, c4);
      chk("fade_step1", 32'(c1), 32'(exp1[w]));
      chk("fade_step4", 32'(c4), 32'(exp4[w]));
    end
    for (int i = 0; i < 32; i++) begin
      step();
      chk("fade_dark1", 32'(out1[3]), 32'h0);
      chk("fade_dark4", 32'(out4[3]), 32'h0);
    end

    // re-trigger at level 6, landing on the decay-tick edge
    pulse_aligned();
    for (int w = 0; w < 12; w++) begin
      window((w == 9) ? 15 : 0, c1, c4);
      if (w <= 9) begin
        chk("retrig_pre1", 32'(c1), 32'(exp1[w]));
        chk("retrig_pre4", 32'(c4), 32'(exp4[w]));
      end else if (w == 10) begin
        chk("retrig_set1", 32'(c1), 32'd16);
        chk("retrig_set4", 32'(c4), 32'd16);
      end else begin
        chk("retrig_next1", 32'(c1), 32'd14);
        chk("retrig_next4", 32'(c4), 32'd11);
      end
    end
    repeat (300) step();

    // knight-rider sweep, then a single-cycle reset
    pos = 0;
    dir = 1;
    for (int i = 0; i < 100; i++) begin
      led_in = 8'(1 << pos);
      step();
      if (i % 4 == 3) begin
        if (pos == 7) dir = -1;
        if (pos == 0) dir = 1;
        pos += dir;
      end
    end
    chk("sweep_lit", 32'(out1 != 8'h00), 32'h1);
    rst = 1'b1;
    step();
    chk("mid_rst_out1", 32'(out1), 32'h0);
    chk("mid_rst_out4", 32'(out4), 32'h0);
    chk("mid_rst_sync", 32'(sync1), 32'h0);
    rst = 1'b0;
    led_in = 8'h00;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("post_rst_out1", 32'(out1), 32'h0);
      chk("post_rst_out4", 32'(out4), 32'h0);
      chk("post_rst_sync", 32'(sync1), 32'(e % 16 == 0));
    end
    led_in = 8'h80;
    step();
    chk("post_lat_k", 32'(out1), 32'h0);
    step();
    chk("post_lat_k1", 32'(out1), 32'h0);
    step();
    chk("post_lat_k2_1", 32'(out1), 32'h80);
    chk("post_lat_k2_4", 32'(out4), 32'h80);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
